// File: rtl/adc_ch_avg_if.sv
// Conversion input and averaged-output bundle between the AD7322 front end, adc_ch_avg and the control loop.
interface adc_ch_avg_if #(
    parameter int DW = 13
) ();
    logic signed [DW-1:0] adc_data;
    logic                 adc_channel;
    logic                 adc_done;
    logic signed [DW-1:0] avg0;
    logic                 avg0_valid;
    logic signed [DW-1:0] avg1;
    logic                 avg1_valid;
    logic                 ovr;

    modport master (
        output adc_data, adc_channel, adc_done,
        input  avg0, avg0_valid, avg1, avg1_valid, ovr
    );

    modport slave (
        input  adc_data, adc_channel, adc_done,
        output avg0, avg0_valid, avg1, avg1_valid, ovr
    );
endinterface

// File: rtl/adc_ch_avg.sv
// Two-lane boxcar averager for AD7322 conversions; one valid pulse per 2**LOG2_N lane samples.
// Optional sticky over-range flag enabled by defining ADC_OVR_EN.
module adc_ch_avg #(
    parameter int LOG2_N = 3,
    parameter int DW     = 13,
    parameter int OVR_TH = 4000
) (
    input logic         clk20MHz,
    input logic         rst,
    adc_ch_avg_if.slave bus
);
    localparam int AW = DW + LOG2_N;
    localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

    typedef enum logic {
        ST_ACC,
        ST_DUMP
    } state_t;

    if (LOG2_N < 0 || LOG2_N > 8) begin : g_chk_log2n
        $error("adc_ch_avg: LOG2_N must be 0..8");
    end
    if (OVR_TH < 1 || OVR_TH > (1 << DW)) begin : g_chk_ovr_th
        $error("adc_ch_avg: OVR_TH out of range for DW");
    end

    logic                 r_done_q;
    logic                 w_take;
    logic signed [AW-1:0] w_sample_ext;

    logic signed [AW-1:0] r_acc   [2];
    logic [CW-1:0]        r_cnt   [2];
    logic signed [DW-1:0] r_avg   [2];
    state_t               r_state [2];
    state_t               w_state_next [2];
    logic                 w_hit   [2];
    logic                 w_last  [2];
    logic                 w_valid [2];
    logic signed [AW-1:0] w_sum   [2];

    // done_q resets high so a done level already present at reset release is ignored
    always_ff @(posedge clk20MHz or posedge rst) begin
        if (rst) begin
            r_done_q <= 1'b1;
        end else begin
            r_done_q <= bus.adc_done;
        end
    end

    assign w_take       = bus.adc_done & ~r_done_q;
    assign w_sample_ext = AW'(bus.adc_data);

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_hit[i]  = w_take && (bus.adc_channel == 1'(i));
            w_last[i] = (r_cnt[i] == CNT_LAST);
            w_sum[i]  = r_acc[i] + w_sample_ext;
        end
    end

    always_ff @(posedge clk20MHz or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_state[i] <= ST_ACC;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_state[i] <= w_state_next[i];
            end
        end
    end

    // DUMP lasts exactly the cycle after the final sample of a block
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_state_next[i] = ST_ACC;
            if (w_hit[i] && w_last[i]) begin
                w_state_next[i] = ST_DUMP;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_valid[i] = (r_state[i] == ST_DUMP);
        end
    end

    always_ff @(posedge clk20MHz or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
                r_avg[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_hit[i]) begin
                    if (w_last[i]) begin
                        r_avg[i] <= DW'(w_sum[i] >>> LOG2_N);
                        r_acc[i] <= '0;
                        r_cnt[i] <= '0;
                    end else begin
                        r_acc[i] <= w_sum[i];
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign bus.avg0       = r_avg[0];
    assign bus.avg0_valid = w_valid[0];
    assign bus.avg1       = r_avg[1];
    assign bus.avg1_valid = w_valid[1];

`ifdef ADC_OVR_EN
    logic signed [DW:0] w_ext;
    logic [DW:0]        w_mag;
    logic               r_ovr;

    // one extra bit so the magnitude of the most negative sample is representable
    assign w_ext = (DW+1)'(bus.adc_data);
    assign w_mag = w_ext[DW] ? (DW+1)'(-w_ext) : w_ext;

    always_ff @(posedge clk20MHz or posedge rst) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else if (w_take && (w_mag >= (DW+1)'(OVR_TH))) begin
            r_ovr <= 1'b1;
        end
    end

    assign bus.ovr = r_ovr;
`else
    assign bus.ovr = 1'b0;
`endif
endmodule

// File: tb/tb_adc_ch_avg.sv
// Bench for adc_ch_avg: LOG2_N=2 averager plus a LOG2_N=0 pass-through instance on identical stimulus.
module tb_adc_ch_avg;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #25 clk = ~clk;

    adc_ch_avg_if #(.DW(13)) a_if ();
    adc_ch_avg_if #(.DW(13)) b_if ();

    adc_ch_avg #(.LOG2_N(2), .DW(13), .OVR_TH(4000)) u_dut (
        .clk20MHz(clk), .rst(rst), .bus(a_if)
    );
    adc_ch_avg #(.LOG2_N(0), .DW(13), .OVR_TH(4000)) u_pt (
        .clk20MHz(clk), .rst(rst), .bus(b_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_coll   = 0;

    // observed streams: lane0 avg, lane1 avg, pass-through (value + lane*100000)
    int obs0[$], obs1[$], obsp[$];
    int exp0[$], exp1[$], expp[$];
    int base_o[3], base_e[3];

    int msum[2], mcnt[2];
    bit exp_ovr = 1'b0;

    always @(negedge clk) begin
        if (a_if.avg0_valid) obs0.push_back(int'(a_if.avg0));
        if (a_if.avg1_valid) obs1.push_back(int'(a_if.avg1));
        if (a_if.avg0_valid && a_if.avg1_valid) n_coll++;
        if (b_if.avg0_valid) obsp.push_back(int'(b_if.avg0));
        if (b_if.avg1_valid) obsp.push_back(int'(b_if.avg1) + 100000);
    end

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int obs_sz(input int l);
        return (l == 0) ? obs0.size() : (l == 1) ? obs1.size() : obsp.size();
    endfunction
    function automatic int exp_sz(input int l);
        return (l == 0) ? exp0.size() : (l == 1) ? exp1.size() : expp.size();
    endfunction
    function automatic int obs_at(input int l, input int i);
        return (l == 0) ? obs0[i] : (l == 1) ? obs1[i] : obsp[i];
    endfunction
    function automatic int exp_at(input int l, input int i);
        return (l == 0) ? exp0[i] : (l == 1) ? exp1[i] : expp[i];
    endfunction

    task automatic mark();
        for (int l = 0; l < 3; l++) begin
            base_o[l] = obs_sz(l);
            base_e[l] = exp_sz(l);
        end
    endtask

    task automatic set_in(input bit done, input bit ch, input int d);
        a_if.adc_done = done; a_if.adc_channel = ch; a_if.adc_data = 13'(d);
        b_if.adc_done = done; b_if.adc_channel = ch; b_if.adc_data = 13'(d);
    endtask

    task automatic model_reset();
        msum[0] = 0; msum[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
        exp_ovr = 1'b0;
    endtask

    // one conversion: done held high for hold cycles, then low; reference model updated
    task automatic take(input bit ch, input int d, input int hold);
        @(posedge clk); #1;
        set_in(1'b1, ch, d);
        msum[ch] += d;
        mcnt[ch]++;
        if (mcnt[ch] == N) begin
            if (ch) exp1.push_back(floor_div(msum[ch], N));
            else    exp0.push_back(floor_div(msum[ch], N));
            msum[ch] = 0;
            mcnt[ch] = 0;
        end
        expp.push_back(d + (ch ? 100000 : 0));
`ifdef ADC_OVR_EN
        if (d >= 4000 || d <= -4000) exp_ovr = 1'b1;
`endif
        repeat (hold) @(posedge clk);
        #1;
        a_if.adc_done = 1'b0;
        b_if.adc_done = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 1234);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a_if.avg0, a_if.avg1, a_if.avg0_valid, a_if.avg1_valid, a_if.ovr} !== '0)
            $display("FAIL reset_outputs: got avg0=%0d avg1=%0d v0=%b v1=%b ovr=%b, required all 0",
                     a_if.avg0, a_if.avg1, a_if.avg0_valid, a_if.avg1_valid, a_if.ovr);
        else n_pass++;
        mark();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 0);
        settle();
        n_checks++;
        if (obs_sz(2) - base_o[2] !== 0)
            $display("FAIL reset_done_high: got %0d pass-through updates, required 0", obs_sz(2) - base_o[2]);
        else n_pass++;
    endtask

    task automatic test_lane0_avg();
        int vals[4] = '{100, 200, 300, 400};
        mark();
        for (int i = 0; i < 3; i++) take(1'b0, vals[i], 1);
        settle();
        n_checks++;
        if (obs_sz(0) - base_o[0] !== 0)
            $display("FAIL lane0_early_valid: got %0d updates after 3 takes, required 0", obs_sz(0) - base_o[0]);
        else n_pass++;
        take(1'b0, vals[3], 1);
        settle();
        n_checks++;
        if (obs_sz(0) - base_o[0] !== 1 || obs0[obs0.size()-1] !== 250)
            $display("FAIL lane0_avg: got %0d updates last=%0d, required 1 update of 250",
                     obs_sz(0) - base_o[0], obs0[obs0.size()-1]);
        else n_pass++;
        n_checks++;
        if (a_if.avg0 !== 13'sd250 || a_if.avg0_valid !== 1'b0)
            $display("FAIL lane0_hold: got avg0=%0d v0=%b, required 250 and 0", a_if.avg0, a_if.avg0_valid);
        else n_pass++;
    endtask

    task automatic test_lane1_avg();
        mark();
        for (int i = 0; i < 4; i++) take(1'b1, -5 - i, 1);
        settle();
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (obs_sz(l) - base_o[l] !== exp_sz(l) - base_e[l])
                $display("FAIL lane1_count s%0d: got %0d, required %0d", l, obs_sz(l) - base_o[l], exp_sz(l) - base_e[l]);
            else n_pass++;
            for (int i = 0; i < exp_sz(l) - base_e[l] && base_o[l] + i < obs_sz(l); i++) begin
                n_checks++;
                if (obs_at(l, base_o[l] + i) !== exp_at(l, base_e[l] + i))
                    $display("FAIL lane1_value s%0d[%0d]: got %0d, required %0d", l, i, obs_at(l, base_o[l] + i), exp_at(l, base_e[l] + i));
                else n_pass++;
            end
        end
        n_checks++;
        if (a_if.avg1 !== -13'sd7 || a_if.avg0 !== 13'sd250)
            $display("FAIL lane1_isolation: got avg1=%0d avg0=%0d, required -7 and 250", a_if.avg1, a_if.avg0);
        else n_pass++;
    endtask

    task automatic test_interleave();
        int coll0 = n_coll;
        mark();
        for (int i = 0; i < 8; i++) take(1'(i), (i % 2) ? -10 : 10, 1);
        settle();
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (obs_sz(l) - base_o[l] !== exp_sz(l) - base_e[l])
                $display("FAIL interleave_count s%0d: got %0d, required %0d", l, obs_sz(l) - base_o[l], exp_sz(l) - base_e[l]);
            else n_pass++;
            for (int i = 0; i < exp_sz(l) - base_e[l] && base_o[l] + i < obs_sz(l); i++) begin
                n_checks++;
                if (obs_at(l, base_o[l] + i) !== exp_at(l, base_e[l] + i))
                    $display("FAIL interleave_value s%0d[%0d]: got %0d, required %0d", l, i, obs_at(l, base_o[l] + i), exp_at(l, base_e[l] + i));
                else n_pass++;
            end
        end
        n_checks++;
        if (n_coll - coll0 !== 0)
            $display("FAIL interleave_collision: got %0d same-cycle valids, required 0", n_coll - coll0);
        else n_pass++;
    endtask

    task automatic test_boundary();
        mark();
        for (int i = 0; i < 4; i++) take(1'b0, 4095, 1);
        for (int i = 0; i < 4; i++) take(1'b0, -4096, 1);
        settle();
        n_checks++;
        if (obs_sz(0) - base_o[0] !== 2)
            $display("FAIL boundary_count: got %0d updates, required 2", obs_sz(0) - base_o[0]);
        else n_pass++;
        n_checks++;
        if (obs_sz(0) - base_o[0] == 2 && (obs0[base_o[0]] !== 4095 || obs0[base_o[0]+1] !== -4096))
            $display("FAIL boundary_value: got %0d,%0d, required 4095,-4096", obs0[base_o[0]], obs0[base_o[0]+1]);
        else n_pass++;
        n_checks++;
        if (a_if.ovr !== exp_ovr)
            $display("FAIL boundary_ovr: got %b, required %b", a_if.ovr, exp_ovr);
        else n_pass++;
    endtask

    task automatic test_hold_and_midreset();
        mark();
        take(1'b0, 500, 5);
        take(1'b0, 700, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a_if.avg0, a_if.avg1, a_if.avg0_valid, a_if.avg1_valid, a_if.ovr, b_if.avg0} !== '0)
            $display("FAIL midreset_outputs: got avg0=%0d avg1=%0d ovr=%b pt=%0d, required all 0",
                     a_if.avg0, a_if.avg1, a_if.ovr, b_if.avg0);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) take(1'b0, 8, 5);
        settle();
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (obs_sz(l) - base_o[l] !== exp_sz(l) - base_e[l])
                $display("FAIL hold_count s%0d: got %0d, required %0d", l, obs_sz(l) - base_o[l], exp_sz(l) - base_e[l]);
            else n_pass++;
            for (int i = 0; i < exp_sz(l) - base_e[l] && base_o[l] + i < obs_sz(l); i++) begin
                n_checks++;
                if (obs_at(l, base_o[l] + i) !== exp_at(l, base_e[l] + i))
                    $display("FAIL hold_value s%0d[%0d]: got %0d, required %0d", l, i, obs_at(l, base_o[l] + i), exp_at(l, base_e[l] + i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_ovr();
        take(1'b0, 3999, 1);
        settle();
        n_checks++;
        if (a_if.ovr !== 1'b0)
            $display("FAIL ovr_below: got %b after 3999, required 0", a_if.ovr);
        else n_pass++;
        take(1'b1, -4000, 1);
        settle();
        n_checks++;
        if (a_if.ovr !== exp_ovr)
            $display("FAIL ovr_neg_th: got %b after -4000, required %b", a_if.ovr, exp_ovr);
        else n_pass++;
        take(1'b1, 0, 1);
        settle();
        n_checks++;
        if (a_if.ovr !== exp_ovr)
            $display("FAIL ovr_sticky: got %b, required %b", a_if.ovr, exp_ovr);
        else n_pass++;
    endtask

    task automatic test_random();
        int coll0 = n_coll;
        mark();
        for (int k = 0; k < 80; k++)
            take(1'($urandom_range(1)), int'($urandom_range(8191)) - 4096, int'($urandom_range(3, 1)));
        settle();
        for (int l = 0; l < 3; l++) begin
            n_checks++;
            if (obs_sz(l) - base_o[l] !== exp_sz(l) - base_e[l])
                $display("FAIL random_count s%0d: got %0d, required %0d", l, obs_sz(l) - base_o[l], exp_sz(l) - base_e[l]);
            else n_pass++;
            for (int i = 0; i < exp_sz(l) - base_e[l] && base_o[l] + i < obs_sz(l); i++) begin
                n_checks++;
                if (obs_at(l, base_o[l] + i) !== exp_at(l, base_e[l] + i))
                    $display("FAIL random_value s%0d[%0d]: got %0d, required %0d", l, i, obs_at(l, base_o[l] + i), exp_at(l, base_e[l] + i));
                else n_pass++;
            end
        end
        n_checks++;
        if (n_coll - coll0 !== 0 || a_if.ovr !== exp_ovr)
            $display("FAIL random_misc: got collisions=%0d ovr=%b, required 0 and %b", n_coll - coll0, a_if.ovr, exp_ovr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lane0_avg();
        test_lane1_avg();
        test_interleave();
        test_boundary();
        test_hold_and_midreset();
        test_ovr();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
